// File: rtl/hazard_scoreboard_pkg.sv
// Shared stage codes, forwarding constants and MDU latency defaults for the
// decode-stage hazard unit.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    STAGE_DECODE  = 2'd0,
    STAGE_EXECUTE = 2'd1,
    STAGE_MEM     = 2'd2,
    STAGE_MAX     = 2'd3
  } stage_e;

  localparam int HAZ_FWD_GRF = 0;
  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT  = 10;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle: read/write codes and MDU controls in, interlock and
// forwarding selects out.
interface hazard_scoreboard_if #(
  parameter int STAGE_W     = 2,
  parameter int NUM_ENTRIES = 3
);
  localparam int FWD_W = $clog2(NUM_ENTRIES + 1);

  logic [4:0]         rs_addr;
  logic [4:0]         rt_addr;
  logic [STAGE_W-1:0] tuse0;
  logic [STAGE_W-1:0] tuse1;
  logic [4:0]         wr_addr;
  logic [STAGE_W-1:0] wr_stage;
  logic               is_md;
  logic               md_start;
  logic               md_div;
  logic               stall;
  logic [FWD_W-1:0]   fwd_sel0;
  logic [FWD_W-1:0]   fwd_sel1;
  logic               md_busy;

  modport master (
    output rs_addr, rt_addr, tuse0, tuse1, wr_addr, wr_stage,
           is_md, md_start, md_div,
    input  stall, fwd_sel0, fwd_sel1, md_busy
  );

  modport slave (
    input  rs_addr, rt_addr, tuse0, tuse1, wr_addr, wr_stage,
           is_md, md_start, md_div,
    output stall, fwd_sel0, fwd_sel1, md_busy
  );

endinterface

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Multiply/divide busy timer: loads the operation latency on issue and counts
// down to idle.
module md_busy_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT,
  parameter int DIV_LAT  = MD_DIV_LAT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_div,
  output logic o_busy
);

  localparam int CNT_W = $clog2(maxInt(MULT_LAT, DIV_LAT) + 1);

  logic [CNT_W-1:0] r_count;

  // A new issue always wins over the running countdown.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_busy = (r_count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage interlock: shift-register scoreboard of in-flight writes with
// cycles-until-ready, stall/forward generation and the MDU busy interlock.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_ENTRIES = 3,
  parameter int STAGE_W     = 2,
  parameter int MULT_LAT    = MD_MULT_LAT,
  parameter int DIV_LAT     = MD_DIV_LAT
) (
  input  logic                clk,
  input  logic                reset_n,
  hazard_scoreboard_if.slave  bus
);

  localparam int                 FWD_W     = $clog2(NUM_ENTRIES + 1);
  localparam logic [STAGE_W-1:0] TUSE_NONE = '1;

  logic [NUM_ENTRIES-1:0] w_match0, w_match1;
  logic [NUM_ENTRIES-1:0] w_late0, w_late1;
  logic [NUM_ENTRIES-1:0] w_ready0, w_ready1;
  logic                   w_dataStall0, w_dataStall1, w_mdStall, w_stall;
  logic                   w_mdBusy;
  logic [FWD_W-1:0]       w_fwdSel0, w_fwdSel1;

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
    logic [4:0]         r_addr;
    logic [STAGE_W-1:0] r_tnew;

    if (gi == 0) begin : g_head
      // A stalled decode leaves a bubble in E instead of its write.
      always_ff @(posedge clk) begin
        if (!reset_n || w_stall) begin
          r_addr <= '0;
          r_tnew <= '0;
        end else begin
          r_addr <= bus.wr_addr;
          r_tnew <= bus.wr_stage;
        end
      end
    end else begin : g_shift
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_addr <= '0;
          r_tnew <= '0;
        end else begin
          r_addr <= g_entry[gi-1].r_addr;
          r_tnew <= (g_entry[gi-1].r_tnew == '0) ? '0
                                                 : g_entry[gi-1].r_tnew - STAGE_W'(1);
        end
      end
    end

    assign w_match0[gi] = (r_addr != 5'd0) && (r_addr == bus.rs_addr);
    assign w_match1[gi] = (r_addr != 5'd0) && (r_addr == bus.rt_addr);
    assign w_late0[gi]  = w_match0[gi] && (r_tnew > bus.tuse0);
    assign w_late1[gi]  = w_match1[gi] && (r_tnew > bus.tuse1);
    assign w_ready0[gi] = w_match0[gi] && (r_tnew == '0);
    assign w_ready1[gi] = w_match1[gi] && (r_tnew == '0);
  end

  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_mdCounter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (bus.md_start && !w_stall),
    .i_div   (bus.md_div),
    .o_busy  (w_mdBusy)
  );

  assign w_dataStall0 = (bus.tuse0 != TUSE_NONE) && (|w_late0);
  assign w_dataStall1 = (bus.tuse1 != TUSE_NONE) && (|w_late1);
  assign w_mdStall    = bus.is_md && w_mdBusy;
  assign w_stall      = w_dataStall0 || w_dataStall1 || w_mdStall;

  // Youngest match decides: a not-yet-ready producer hides older copies.
  always_comb begin
    w_fwdSel0 = FWD_W'(HAZ_FWD_GRF);
    w_fwdSel1 = FWD_W'(HAZ_FWD_GRF);
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_match0[i]) w_fwdSel0 = w_ready0[i] ? FWD_W'(i + 1) : FWD_W'(HAZ_FWD_GRF);
      if (w_match1[i]) w_fwdSel1 = w_ready1[i] ? FWD_W'(i + 1) : FWD_W'(HAZ_FWD_GRF);
    end
  end

  assign bus.stall    = w_stall;
  assign bus.fwd_sel0 = w_fwdSel0;
  assign bus.fwd_sel1 = w_fwdSel1;
  assign bus.md_busy  = w_mdBusy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, ALU/load forwarding, register 0,
// MDU interlock and reset during a divide.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk;
  logic reset_n;
  int   checkCount;
  int   errorCount;

  hazard_scoreboard_if #(.STAGE_W(2), .NUM_ENTRIES(3)) bus ();

  hazard_scoreboard #(
    .NUM_ENTRIES (3),
    .STAGE_W     (2),
    .MULT_LAT    (5),
    .DIV_LAT     (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one decode cycle at the falling edge and let outputs settle.
  task automatic applyStimulus(input logic [4:0] rs, input stage_e t0,
                               input logic [4:0] rt, input stage_e t1,
                               input logic [4:0] wr, input stage_e ws,
                               input logic isMd, input logic mdStart,
                               input logic mdDiv);
    @(negedge clk);
    bus.rs_addr  = rs;
    bus.tuse0    = t0;
    bus.rt_addr  = rt;
    bus.tuse1    = t1;
    bus.wr_addr  = wr;
    bus.wr_stage = ws;
    bus.is_md    = isMd;
    bus.md_start = mdStart;
    bus.md_div   = mdDiv;
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset_n    = 1'b0;
    bus.rs_addr = '0; bus.tuse0 = STAGE_MAX; bus.rt_addr = '0; bus.tuse1 = STAGE_MAX;
    bus.wr_addr = '0; bus.wr_stage = STAGE_DECODE;
    bus.is_md = 1'b0; bus.md_start = 1'b0; bus.md_div = 1'b0;

    // Reset held for two edges with a live read on port 0
    for (int c = 0; c < 2; c++) begin
      applyStimulus(5'd5, STAGE_EXECUTE, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);
      checkOutput("reset_stall", bus.stall, 0);
      checkOutput("reset_fwd0", bus.fwd_sel0, 0);
      checkOutput("reset_busy", bus.md_busy, 0);
    end
    reset_n = 1'b1;

    // ALU producer then EXECUTE-use consumer
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd8, STAGE_EXECUTE, 0, 0, 0);
    checkOutput("alu_issue_stall", bus.stall, 0);
    applyStimulus(5'd8, STAGE_EXECUTE, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);
    checkOutput("alu_use_stall", bus.stall, 0);
    checkOutput("alu_use_fwd0", bus.fwd_sel0, 0);
    applyStimulus(5'd8, STAGE_EXECUTE, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);
    checkOutput("alu_m_stall", bus.stall, 0);
    checkOutput("alu_m_fwd0", bus.fwd_sel0, 2);

    // Load producer then EXECUTE-use on port 1: one stall cycle
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd9, STAGE_MEM, 0, 0, 0);
    applyStimulus(5'd0, STAGE_MAX, 5'd9, STAGE_EXECUTE, 5'd0, STAGE_DECODE, 0, 0, 0);
    checkOutput("lw_ex_stall1", bus.stall, 1);
    applyStimulus(5'd0, STAGE_MAX, 5'd9, STAGE_EXECUTE, 5'd0, STAGE_DECODE, 0, 0, 0);
    checkOutput("lw_ex_stall2", bus.stall, 0);
    checkOutput("lw_ex_fwd1", bus.fwd_sel1, 0);
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);

    // Load producer then DECODE-use (branch): two stall cycles then W forward
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd9, STAGE_MEM, 0, 0, 0);
    applyStimulus(5'd0, STAGE_MAX, 5'd9, STAGE_DECODE, 5'd0, STAGE_DECODE, 0, 0, 0);
    checkOutput("lw_id_stall1", bus.stall, 1);
    applyStimulus(5'd0, STAGE_MAX, 5'd9, STAGE_DECODE, 5'd0, STAGE_DECODE, 0, 0, 0);
    checkOutput("lw_id_stall2", bus.stall, 1);
    applyStimulus(5'd0, STAGE_MAX, 5'd9, STAGE_DECODE, 5'd0, STAGE_DECODE, 0, 0, 0);
    checkOutput("lw_id_stall3", bus.stall, 0);
    checkOutput("lw_id_fwd1", bus.fwd_sel1, 3);

    // Register 0 never stalls or forwards
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_MEM, 0, 0, 0);
    applyStimulus(5'd0, STAGE_DECODE, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);
    checkOutput("r0_stall", bus.stall, 0);
    checkOutput("r0_fwd0", bus.fwd_sel0, 0);

    // Younger pending write to $10 hides a ready older one
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd10, STAGE_EXECUTE, 0, 0, 0);
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd10, STAGE_MEM, 0, 0, 0);
    applyStimulus(5'd10, STAGE_MEM, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);
    checkOutput("shadow_stall", bus.stall, 0);
    checkOutput("shadow_fwd0", bus.fwd_sel0, 0);

    // Divide issue: 10 busy cycles, non-MD passes, MD waits
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1, 1, 1);
    checkOutput("div_issue_stall", bus.stall, 0);
    checkOutput("div_issue_busy", bus.md_busy, 0);
    for (int c = 1; c <= 2; c++) begin
      applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);
      checkOutput("div_nonmd_busy", bus.md_busy, 1);
      checkOutput("div_nonmd_stall", bus.stall, 0);
    end
    for (int c = 3; c <= 10; c++) begin
      applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1, 1, 0);
      checkOutput("div_md_busy", bus.md_busy, 1);
      checkOutput("div_md_stall", bus.stall, 1);
    end
    // Busy drops; the waiting multiply finally issues
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1, 1, 0);
    checkOutput("div_end_busy", bus.md_busy, 0);
    checkOutput("div_end_stall", bus.stall, 0);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);
      checkOutput("mult_busy", bus.md_busy, 1);
    end
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);
    checkOutput("mult_end_busy", bus.md_busy, 0);

    // Reset at cycle 4 of a divide, with a load to $5 in flight
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1, 1, 1);
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd5, STAGE_MEM, 0, 0, 0);
    applyStimulus(5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 0, 0, 0);
    checkOutput("midrst_pre_busy", bus.md_busy, 1);
    reset_n = 1'b0;
    applyStimulus(5'd5, STAGE_DECODE, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1, 0, 0);
    reset_n = 1'b1;
    checkOutput("midrst_busy", bus.md_busy, 0);
    checkOutput("midrst_stall", bus.stall, 0);
    checkOutput("midrst_fwd0", bus.fwd_sel0, 0);
    applyStimulus(5'd5, STAGE_DECODE, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1, 0, 0);
    checkOutput("midrst_after_busy", bus.md_busy, 0);
    checkOutput("midrst_after_stall", bus.stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
